// File: rtl/cpu_control_sequencer.sv
// Hardwired multi-cycle controller: two-byte fetch, decode, and per-T-state datapath control.
// Optional macro SINGLE_STEP_EN adds a Step input and a WAIT state between instructions.
module cpu_control_sequencer #(
  parameter logic [5:0] HALT_OP    = 6'h3F,
  parameter logic [2:0] PC_INC_FUN = 3'b001
) (
  input  logic        Clock,
  input  logic        Reset,
`ifdef SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IROut,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  SeqT,
  output logic        Halted,
  output logic        IllegalOp
);

  typedef enum logic [2:0] {FETCH_L, FETCH_H, EXEC, HALT, WAIT} state_t;

  localparam logic [5:0] OP_BRA = 6'h00, OP_BNE = 6'h01, OP_BEQ = 6'h02;
  localparam logic [5:0] OP_ADD = 6'h04, OP_SUB = 6'h05, OP_AND = 6'h06;
  localparam logic [5:0] OP_ORR = 6'h07, OP_XOR = 6'h08;
  localparam logic [5:0] OP_LDI = 6'h10, OP_LDM = 6'h11, OP_STM = 6'h12;
  localparam logic [2:0] FUN_LOAD = 3'b010;

`ifdef SINGLE_STEP_EN
  localparam state_t DONE_STATE = WAIT;
`else
  localparam state_t DONE_STATE = FETCH_L;
`endif

  state_t      state;
  logic [2:0]  seq_t;
  logic        illegal_op;
  logic [5:0]  opcode;
  logic [1:0]  rd, rs1, rs2;
  logic        zero;
  logic        known_op;
  logic        unused_bits;

  assign opcode      = IROut[15:10];
  assign rd          = IROut[9:8];
  assign rs1         = IROut[7:6];
  assign rs2         = IROut[5:4];
  assign zero        = Flags[3];
  assign unused_bits = ^{IROut[3:0], Flags[2:0]};

  function automatic logic [3:0] reg_en(input logic [1:0] k);
    return ~(4'b1000 >> k);
  endfunction

  function automatic logic [4:0] alu_code(input logic [5:0] op);
    case (op)
      OP_ADD:  return 5'b10100;
      OP_SUB:  return 5'b10110;
      OP_AND:  return 5'b10111;
      OP_ORR:  return 5'b11000;
      default: return 5'b11001;
    endcase
  endfunction

  always_comb begin
    known_op = 1'b0;
    case (opcode)
      OP_BRA, OP_BNE, OP_BEQ, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR,
      OP_LDI, OP_LDM, OP_STM: known_op = 1'b1;
      default:                known_op = (opcode == HALT_OP);
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= FETCH_L;
      seq_t      <= 3'd0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        FETCH_L: begin state <= FETCH_H; seq_t <= 3'd1; end
        FETCH_H: begin state <= EXEC;    seq_t <= 3'd2; end
        EXEC: begin
          if (opcode == HALT_OP) begin
            state <= HALT;
            seq_t <= 3'd0;
          end else if ((opcode == OP_LDM || opcode == OP_STM) && seq_t == 3'd2) begin
            seq_t <= 3'd3;
          end else begin
            state <= DONE_STATE;
            seq_t <= 3'd0;
          end
          if (!known_op) illegal_op <= 1'b1;
        end
        HALT: begin state <= HALT; seq_t <= 3'd0; end
`ifdef SINGLE_STEP_EN
        WAIT: begin
          if (Step) state <= FETCH_L;
          seq_t <= 3'd0;
        end
`endif
        default: begin state <= FETCH_L; seq_t <= 3'd0; end
      endcase
    end
  end

  assign SeqT      = seq_t;
  assign Halted    = (state == HALT);
  assign IllegalOp = illegal_op;

  // Control word: idle by default; the Reset gate keeps it idle while reset is held.
  always_comb begin
    RF_OutASel = 3'd0;  RF_OutBSel = 3'd0;  RF_FunSel  = 3'd0;
    RF_RegSel  = 4'hF;  RF_ScrSel  = 4'hF;  ALU_FunSel = 5'd0;  ALU_WF = 1'b0;
    ARF_OutCSel = 2'd0; ARF_OutDSel = 2'd0; ARF_FunSel = 3'd0;  ARF_RegSel = 3'b111;
    IR_LH = 1'b0; IR_Write = 1'b0; Mem_WR = 1'b0; Mem_CS = 1'b1;
    MuxASel = 2'd0; MuxBSel = 2'd0; MuxCSel = 1'b0;
    if (Reset) begin
      case (state)
        FETCH_L, FETCH_H: begin
          Mem_CS     = 1'b0;
          IR_Write   = 1'b1;
          IR_LH      = (state == FETCH_H);
          ARF_FunSel = PC_INC_FUN;
          ARF_RegSel = 3'b011;
        end
        EXEC: begin
          case (opcode)
            OP_BRA, OP_BNE, OP_BEQ: begin
              if (opcode == OP_BRA || (opcode == OP_BNE && !zero) || (opcode == OP_BEQ && zero)) begin
                MuxBSel    = 2'b11;
                ARF_FunSel = FUN_LOAD;
                ARF_RegSel = 3'b011;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR: begin
              RF_OutASel = {1'b0, rs1};
              RF_OutBSel = {1'b0, rs2};
              ALU_FunSel = alu_code(opcode);
              ALU_WF     = 1'b1;
              RF_FunSel  = FUN_LOAD;
              RF_RegSel  = reg_en(rd);
            end
            OP_LDI: begin
              MuxASel   = 2'b11;
              RF_FunSel = FUN_LOAD;
              RF_RegSel = reg_en(rd);
            end
            OP_LDM, OP_STM: begin
              if (seq_t == 3'd2) begin
                MuxBSel    = 2'b11;
                ARF_FunSel = FUN_LOAD;
                ARF_RegSel = 3'b101;
              end else begin
                ARF_OutDSel = 2'b10;
                Mem_CS      = 1'b0;
                if (opcode == OP_LDM) begin
                  MuxASel   = 2'b10;
                  RF_FunSel = FUN_LOAD;
                  RF_RegSel = reg_en(rd);
                end else begin
                  RF_OutASel = {1'b0, rd};
                  ALU_FunSel = 5'b10000;
                  Mem_WR     = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: expected control words are queued per cycle and checked.
module tb_cpu_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  Flags;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  SeqT;
  logic        Halted, IllegalOp;

  typedef struct packed {
    logic [2:0] a_sel, b_sel, rf_fun;
    logic [3:0] rf_reg, rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] c_sel, d_sel;
    logic [2:0] arf_fun, arf_reg;
    logic       ir_lh, ir_write, mem_wr, mem_cs;
    logic [1:0] mux_a, mux_b;
    logic       mux_c;
    logic [2:0] seq_t;
    logic       halted, illegal;
  } word_t;

  word_t obs;
  word_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    passes = 0;
  logic  exp_ill = 1'b0;

  cpu_control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .SeqT(SeqT), .Halted(Halted), .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  assign obs = '{RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
                 ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR,
                 Mem_CS, MuxASel, MuxBSel, MuxCSel, SeqT, Halted, IllegalOp};

  function automatic word_t idle_w(input logic [2:0] seq);
    word_t w = '0;
    w.rf_reg  = 4'hF;
    w.rf_scr  = 4'hF;
    w.arf_reg = 3'b111;
    w.mem_cs  = 1'b1;
    w.seq_t   = seq;
    w.illegal = exp_ill;
    return w;
  endfunction

  function automatic word_t fetch_w(input logic lh);
    word_t w = idle_w(lh ? 3'd1 : 3'd0);
    w.mem_cs   = 1'b0;
    w.ir_write = 1'b1;
    w.ir_lh    = lh;
    w.arf_fun  = 3'b001;
    w.arf_reg  = 3'b011;
    return w;
  endfunction

  function automatic word_t branch_w();
    word_t w = idle_w(3'd2);
    w.mux_b   = 2'b11;
    w.arf_fun = 3'b010;
    w.arf_reg = 3'b011;
    return w;
  endfunction

  function automatic word_t alu_w(input logic [2:0] a, input logic [2:0] b,
                                  input logic [4:0] fun, input logic [3:0] en);
    word_t w = idle_w(3'd2);
    w.a_sel   = a;
    w.b_sel   = b;
    w.alu_fun = fun;
    w.alu_wf  = 1'b1;
    w.rf_fun  = 3'b010;
    w.rf_reg  = en;
    return w;
  endfunction

  function automatic word_t ar_load_w();
    word_t w = idle_w(3'd2);
    w.mux_b   = 2'b11;
    w.arf_fun = 3'b010;
    w.arf_reg = 3'b101;
    return w;
  endfunction

  task automatic push_exp(input string tag, input word_t w);
    exp_q.push_back(w);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    word_t e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) passes++;
    else $error("FAIL %s: observed %h expected %h", t, obs, e);
  endtask

  task automatic expect_cycle(input string tag, input word_t w);
    push_exp(tag, w);
    #1;
    pop_check();
    @(negedge Clock);
  endtask

  task automatic fetch_pair();
    expect_cycle("fetch_l", fetch_w(1'b0));
    expect_cycle("fetch_h", fetch_w(1'b1));
  endtask

  initial begin
    word_t w;
    Reset = 1'b0;
    IROut = 16'h0000;
    Flags = 4'b0000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    push_exp("reset_idle", idle_w(3'd0));
    #1;
    pop_check();
    Reset = 1'b1;

    // LDI R1, 0xA5
    IROut = 16'h40A5;
    fetch_pair();
    w = idle_w(3'd2); w.mux_a = 2'b11; w.rf_fun = 3'b010; w.rf_reg = 4'b0111;
    expect_cycle("ldi_t2", w);

    // ADD R1 = R1 + R2
    IROut = 16'h1018;
    fetch_pair();
    expect_cycle("add_t2", alu_w(3'd0, 3'd1, 5'b10100, 4'b0111));

    // SUB R4 = R3 - R2
    IROut = 16'h1790;
    fetch_pair();
    expect_cycle("sub_t2", alu_w(3'd2, 3'd1, 5'b10110, 4'b1110));

    // BEQ not taken, then taken
    IROut = 16'h0830;
    Flags = 4'b0000;
    fetch_pair();
    expect_cycle("beq_nt", idle_w(3'd2));
    Flags = 4'b1000;
    fetch_pair();
    expect_cycle("beq_t", branch_w());

    // BNE with Z=1 is not taken
    IROut = 16'h0412;
    fetch_pair();
    expect_cycle("bne_nt", idle_w(3'd2));
    Flags = 4'b0000;

    // LDM R3, 0x55
    IROut = 16'h4655;
    fetch_pair();
    expect_cycle("ldm_t2", ar_load_w());
    w = idle_w(3'd3); w.d_sel = 2'b10; w.mem_cs = 1'b0; w.mux_a = 2'b10;
    w.rf_fun = 3'b010; w.rf_reg = 4'b1101;
    expect_cycle("ldm_t3", w);

    // STM R2, 0x40 with reset asserted during T3
    IROut = 16'h4940;
    fetch_pair();
    expect_cycle("stm_t2", ar_load_w());
    w = idle_w(3'd3); w.a_sel = 3'd1; w.alu_fun = 5'b10000; w.d_sel = 2'b10;
    w.mem_cs = 1'b0; w.mem_wr = 1'b1;
    push_exp("stm_t3", w);
    #1;
    pop_check();
    Reset = 1'b0;
    push_exp("reset_mid_t3", idle_w(3'd0));
    #1;
    pop_check();
    @(negedge Clock);
    push_exp("reset_hold", idle_w(3'd0));
    #1;
    pop_check();
    Reset = 1'b1;

    // Undefined opcode 0x1F: NOP, IllegalOp sets and refetch follows
    IROut = 16'h7C00;
    fetch_pair();
    expect_cycle("illegal_t2", idle_w(3'd2));
    exp_ill = 1'b1;
    IROut = 16'hFC00;
    fetch_pair();

    // HALT
    expect_cycle("halt_t2", idle_w(3'd2));
    w = idle_w(3'd0); w.halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      Flags = 4'(i);
      IROut = 16'(i * 16'h0511);
      expect_cycle("halted", w);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
